// File: rtl/i2c_slave_pkg.sv
// Shared constants for the write-only I2C target: FSM encoding, default address, bit-count width.
// No logic lives here; latency and backpressure are properties of the modules that import it.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } state_t;

    localparam logic [7:0] DEFAULT_ADDR = 8'h78;
    localparam int         BIT_CNT_W    = 3;

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-FF synchronizer plus history register; level/rise/fall valid 3 CLK after a pin edge.
// No backpressure: every sample is consumed. Resets to 1 so an idle bus shows no edge.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_l,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;
    logic hist_d, hist_q;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_slave.sv
// Write-only I2C target: ACKs its address, strobes each data byte 1 CLK after the 8th SCL fall.
// RX_READY=0 at byte completion NACKs the byte and pulses OVERRUN; SCL is never stretched.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [7:0] ADDR = DEFAULT_ADDR
) (
    input  logic       CLK,
    input  logic       ASYNC_RST_L,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic       RX_READY,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    output logic       DATA_FIRST,
    output logic       ACTIVE,
    output logic       OVERRUN
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk   (CLK),
        .rst_l (ASYNC_RST_L),
        .din   (SCL),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (CLK),
        .rst_l (ASYNC_RST_L),
        .din   (SDA),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    state_t                 state_d, state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d, bit_cnt_q;
    logic                   done_d, done_q;
    logic [7:0]             shift_d, shift_q;
    logic                   sda_oe_d, sda_oe_q;
    logic                   active_d, active_q;
    logic                   first_d, first_q;
    logic [7:0]             data_d, data_q;
    logic                   data_valid_d, data_valid_q;
    logic                   data_first_d, data_first_q;
    logic                   overrun_d, overrun_q;

    // An SCL change in the same sample as SDA wins, so it can never look like START/STOP.
    logic start_evt, stop_evt, byte_done, shifting, addr_match;
    assign start_evt  = sda_fall && scl_lvl && !scl_rise && !scl_fall;
    assign stop_evt   = sda_rise && scl_lvl && !scl_rise && !scl_fall;
    assign byte_done  = scl_fall && done_q;
    assign shifting   = scl_rise && !done_q && (state_q == ST_ADDR || state_q == ST_DATA);
    assign addr_match = (shift_q[7:1] == ADDR[7:1]) && !shift_q[0];

    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_evt) begin
            state_d = ST_ADDR;
        end else if (stop_evt) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR:     if (byte_done) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: if (scl_fall)  state_d = ST_DATA;
                ST_DATA:     if (byte_done) state_d = ST_DATA_ACK;
                ST_DATA_ACK: if (scl_fall)  state_d = ST_DATA;
                default:     state_d = state_q;
            endcase
        end
    end

    // Done flag blocks further shifting until the ACK slot has passed.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        shift_d   = shift_q;
        if (start_evt || stop_evt) begin
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end else if (shifting) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == '1) done_d = 1'b1;
        end else if (byte_done) begin
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    always_comb begin
        sda_oe_d     = sda_oe_q;
        active_d     = active_q;
        first_d      = first_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        data_first_d = 1'b0;
        overrun_d    = 1'b0;
        if (start_evt || stop_evt) begin
            sda_oe_d = 1'b0;
            active_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (byte_done && addr_match) begin
                        sda_oe_d = 1'b1;
                        active_d = 1'b1;
                        first_d  = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        sda_oe_d = RX_READY;
                        if (RX_READY) begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                            data_first_d = first_q;
                            first_d      = 1'b0;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) sda_oe_d = 1'b0;
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
        if (!ASYNC_RST_L) begin
            bit_cnt_q    <= '0;
            done_q       <= 1'b0;
            shift_q      <= 8'h00;
            sda_oe_q     <= 1'b0;
            active_q     <= 1'b0;
            first_q      <= 1'b0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            data_first_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            done_q       <= done_d;
            shift_q      <= shift_d;
            sda_oe_q     <= sda_oe_d;
            active_q     <= active_d;
            first_q      <= first_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            data_first_q <= data_first_d;
            overrun_q    <= overrun_d;
        end
    end

    assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
    assign DATA       = data_q;
    assign DATA_VALID = data_valid_q;
    assign DATA_FIRST = data_first_q;
    assign ACTIVE     = active_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master at 40 CLK per SCL period, strobe monitor.
// Expected bytes, flags and ACK/NACK outcomes are hand-derived per transaction.
module tb_i2c_slave;

    logic       clk       = 1'b0;
    logic       rst_l     = 1'b0;
    logic       m_scl     = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       rx_ready  = 1'b1;
    tri1        sda_w;
    logic [7:0] data;
    logic       data_valid, data_first, active, overrun;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] strobes[$];
    int         ovr_cnt     = 0;
    logic       active_seen = 1'b0;
    logic       dut_drove   = 1'b0;
    logic       ack;

    always #5 clk = ~clk;

    assign sda_w = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.ADDR(8'h78)) dut (
        .CLK         (clk),
        .ASYNC_RST_L (rst_l),
        .SCL         (m_scl),
        .SDA         (sda_w),
        .RX_READY    (rx_ready),
        .DATA        (data),
        .DATA_VALID  (data_valid),
        .DATA_FIRST  (data_first),
        .ACTIVE      (active),
        .OVERRUN     (overrun)
    );

    always @(negedge clk) begin
        if (data_valid) strobes.push_back({data_first, data});
        if (overrun) ovr_cnt++;
        if (active) active_seen = 1'b1;
        if (sda_w === 1'b0 && !m_sda_low) dut_drove = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] strobe_at(input int idx);
        if (idx < strobes.size()) return strobes[idx];
        return 9'h1FF;
    endfunction

    task automatic clr_mon();
        strobes.delete();
        ovr_cnt     = 0;
        active_seen = 1'b0;
        dut_drove   = 1'b0;
    endtask

    task automatic qw();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        qw();
        m_scl = 1'b1;
        qw();
        m_sda_low = 1'b1;
        qw();
        m_scl = 1'b0;
        qw();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        qw();
        m_scl = 1'b1;
        qw();
        m_sda_low = 1'b0;
        qw();
        qw();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;
        qw();
        m_scl = 1'b1;
        qw();
        qw();
        m_scl = 1'b0;
        qw();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_o);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0;
        qw();
        m_scl = 1'b1;
        qw();
        ack_o = (sda_w === 1'b0);
        qw();
        m_scl = 1'b0;
        qw();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  data, 8'h00);
        check("rst_vld",   data_valid, 1'b0);
        check("rst_first", data_first, 1'b0);
        check("rst_act",   active, 1'b0);
        check("rst_ovr",   overrun, 1'b0);
        check("rst_sda",   sda_w, 1'b1);
        rst_l = 1'b1;
        qw();

        // Two ACKed data bytes
        clr_mon();
        i2c_start();
        send_byte(8'h78, ack);
        check("t1_addr_ack", ack, 1'b1);
        check("t1_active", active, 1'b1);
        send_byte(8'h00, ack);
        check("t1_b0_ack", ack, 1'b1);
        send_byte(8'hAF, ack);
        check("t1_b1_ack", ack, 1'b1);
        i2c_stop();
        check("t1_nstrobe", strobes.size(), 2);
        check("t1_strobe0", strobe_at(0), {1'b1, 8'h00});
        check("t1_strobe1", strobe_at(1), {1'b0, 8'hAF});
        check("t1_act_stop", active, 1'b0);
        check("t1_data_hold", data, 8'hAF);

        // Wrong address
        clr_mon();
        i2c_start();
        send_byte(8'h7A, ack);
        check("t2_addr_nack", ack, 1'b0);
        send_byte(8'h55, ack);
        check("t2_data_nack", ack, 1'b0);
        i2c_stop();
        check("t2_nstrobe", strobes.size(), 0);
        check("t2_sda_drv", dut_drove, 1'b0);
        check("t2_act_seen", active_seen, 1'b0);

        // Read request is ignored until STOP
        clr_mon();
        i2c_start();
        send_byte(8'h79, ack);
        check("t3_addr_nack", ack, 1'b0);
        send_byte(8'h12, ack);
        check("t3_data_nack", ack, 1'b0);
        i2c_stop();
        check("t3_nstrobe", strobes.size(), 0);
        check("t3_act_seen", active_seen, 1'b0);

        // Overrun then accepted byte keeps first flag
        clr_mon();
        i2c_start();
        send_byte(8'h78, ack);
        check("t4_addr_ack", ack, 1'b1);
        rx_ready = 1'b0;
        send_byte(8'h11, ack);
        check("t4_ovr_nack", ack, 1'b0);
        check("t4_ovr_cnt", ovr_cnt, 1);
        check("t4_nstrobe0", strobes.size(), 0);
        check("t4_data_keep", data, 8'hAF);
        rx_ready = 1'b1;
        send_byte(8'h22, ack);
        check("t4_b_ack", ack, 1'b1);
        i2c_stop();
        check("t4_nstrobe1", strobes.size(), 1);
        check("t4_strobe0", strobe_at(0), {1'b1, 8'h22});

        // Partial byte aborted by repeated START
        clr_mon();
        i2c_start();
        send_byte(8'h78, ack);
        check("t5_addr_ack", ack, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_start();
        send_byte(8'h78, ack);
        check("t5_readdr_ack", ack, 1'b1);
        send_byte(8'h3C, ack);
        check("t5_b_ack", ack, 1'b1);
        i2c_stop();
        check("t5_nstrobe", strobes.size(), 1);
        check("t5_strobe0", strobe_at(0), {1'b1, 8'h3C});

        // Reset during the data ACK drive
        clr_mon();
        i2c_start();
        send_byte(8'h78, ack);
        check("t6_addr_ack", ack, 1'b1);
        for (int i = 7; i >= 0; i--) send_bit(((8'h5A >> i) & 8'h01) != 8'h00);
        m_sda_low = 1'b0;
        #1;
        check("t6_ack_drv", sda_w, 1'b0);
        check("t6_strobe0", strobe_at(0), {1'b1, 8'h5A});
        rst_l = 1'b0;
        #1;
        check("t6_rst_sda", sda_w, 1'b1);
        check("t6_rst_data", data, 8'h00);
        check("t6_rst_act", active, 1'b0);
        qw();
        rst_l = 1'b1;
        qw();
        m_scl = 1'b1;
        qw();
        m_scl = 1'b0;
        qw();
        i2c_stop();
        i2c_start();
        send_byte(8'h78, ack);
        check("t6_post_ack", ack, 1'b1);
        check("t6_post_act", active, 1'b1);
        i2c_stop();
        check("t6_post_stop", active, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Write-only I2C target that receives the byte stream an I2C master produces: START, 8-bit address byte, data bytes, STOP. It ACKs its own address, shifts in each data byte and presents it on a parallel port with a one-cycle strobe. It serves as a bench/loopback model for display command traffic and as the on-chip receive end of a board-to-board command link. It is fully synchronous to `CLK` and oversamples `SCL`/`SDA`. It never stretches the clock.

## Interface
- `ADDR`, 8'h78 — target address in 8-bit write form; only `ADDR[7:1]` is compared (7-bit 0x3C).
- `CLK` input 1 — system clock, rising edge; frequency ≥ 8× SCL.
- `ASYNC_RST_L` input 1 — reset, asynchronous, active-low.
- `SCL` input 1 — I2C clock from bus (asynchronous).
- `SDA` inout 1 — I2C data, open-drain: driven 0 or `z`, never 1.
- `RX_READY` input 1 — consumer can accept a byte; sampled when a byte completes.
- `DATA` output 8 — last received data byte.
- `DATA_VALID` output 1 — one-cycle strobe, `DATA` new.
- `DATA_FIRST` output 1 — qualifies `DATA_VALID`: first byte after address.
- `ACTIVE` output 1 — addressed transaction in progress.
- `OVERRUN` output 1 — one-cycle pulse: byte NACKed because `RX_READY`=0.

## Operation
- Input conditioning:
  - `SCL`/`SDA` pass through 2-FF synchronizers plus one history register.
  - Rise/fall detected from the last two synchronized samples.
- Bus events, priority order:
  - START: SDA fall while SCL high.
  - STOP: SDA rise while SCL high.
  - Data bit: sampled on SCL rise.
  - Transitions: act on SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - START from any state → ADDR, bit counter = 0, `ACTIVE`=0. A repeated START is handled identically.
  - STOP from any state → IDLE, `ACTIVE`=0, SDA released.
  - ADDR: shift 8 bits MSB first. On the 8th SCL fall:
    - `addr[7:1]`==`ADDR[7:1]` and R/W=0 → ADDR_ACK, drive SDA=0, `ACTIVE`=1, set first flag.
    - otherwise (mismatch or read) → IGNORE, SDA released.
  - ADDR_ACK: on next SCL fall release SDA → DATA.
  - DATA: shift 8 bits. On the 8th SCL fall:
    - `RX_READY`=1 → load `DATA`, pulse `DATA_VALID` (`DATA_FIRST`=first flag), clear first flag, drive SDA=0 → DATA_ACK.
    - `RX_READY`=0 → pulse `OVERRUN`, SDA released (NACK), `DATA` unchanged, first flag kept → DATA_ACK.
  - DATA_ACK: on next SCL fall release SDA → DATA, counter = 0.
  - IGNORE: SDA never driven; leaves only on START/STOP.
- Width rules:
  - Bit counter 3 bits plus done flag; no wrap into byte 2 without an ACK slot.
  - Shift register 8 bits.

## Timing
- Reset values:
  - state IDLE, SDA `z`, `DATA`=8'h00.
  - `DATA_VALID`, `DATA_FIRST`, `ACTIVE`, `OVERRUN` all = 0.
- Event latency: 3 CLK from pin edge to detection (2 sync + 1 edge).
- `DATA_VALID`/`OVERRUN`: asserted exactly 1 CLK, in the cycle after the 8th SCL fall is detected. `DATA` holds until the next valid byte.
- ACK drive: SDA low starts ≤1 CLK after 8th SCL fall detection and is released ≤1 CLK after the 9th SCL fall detection. With ≥8× oversampling this meets setup for the master's 9th rising edge.
- `RX_READY` is sampled only in the completing cycle.
- Simultaneous SDA and SCL change in the same sample: treated as SCL event only; no START/STOP.
- Reset mid-transaction: SDA released immediately (asynchronous); all outputs reset.
- START during ADDR_ACK/DATA_ACK: SDA released, and no strobe fires for the partial byte.

## Structure
- Shared package constants: FSM state encoding, default address 8'h78, bit-count width.
- One sub-module, `i2c_sync_edge`: 2-FF synchronizer plus edge detector, instantiated for SCL and SDA. Outputs: level, rise, fall.
- SDA tristate assign lives in this top block.

## Test plan
- START, 0x78, 0x00, 0xAF, STOP, `RX_READY`=1 → both bytes ACKed.
  - Strobe 1: `DATA`=0x00 with `DATA_FIRST`=1.
  - Strobe 2: `DATA`=0xAF with `DATA_FIRST`=0.
  - `ACTIVE` falls after STOP.
- START, 0x7A, 0x55, STOP → address NACKed, SDA never low, no strobe, `ACTIVE`=0 throughout.
- START, 0x79 (read) → NACK, IGNORE until STOP.
- START, 0x78, 0x11 with `RX_READY`=0 → `OVERRUN` pulse, NACK on 9th clock, `DATA` keeps prior value. Next byte 0x22 with `RX_READY`=1 → strobe with `DATA_FIRST`=1.
- START, 0x78, 4 bits, repeated START, 0x78, 0x3C, STOP → no strobe for the partial byte; one strobe with 0x3C.
- Assert `ASYNC_RST_L` low during the DATA_ACK drive → SDA goes `z` the same cycle. After release the next START + 0x78 is ACKed normally.
